// File: rtl/mor1kx_branch_resolve_simple_if.sv
// Branch-resolve bus: decode capture, execute flag, redirect and statistics.
interface mor1kx_branch_resolve_simple_if #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int CNT_WIDTH            = 16
);
    logic                            padv_decode_i;
    logic                            op_bf_i;
    logic                            op_bnf_i;
    logic                            predicted_flag_i;
    logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_i;
    logic [25:0]                     immjbr_i;
    logic                            flag_valid_i;
    logic                            flag_i;
    logic                            pipeline_flush_i;
    logic                            busy_o;
    logic                            mispredict_o;
    logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;
    logic [CNT_WIDTH-1:0]            branch_cnt_o;
    logic [CNT_WIDTH-1:0]            mispredict_cnt_o;

    // Pipeline side: drives decode/execute information, consumes the verdict.
    modport master (
        output padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i, pc_decode_i,
               immjbr_i, flag_valid_i, flag_i, pipeline_flush_i,
        input  busy_o, mispredict_o, redirect_pc_o, branch_cnt_o, mispredict_cnt_o
    );

    // Resolver side.
    modport slave (
        input  padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i, pc_decode_i,
               immjbr_i, flag_valid_i, flag_i, pipeline_flush_i,
        output busy_o, mispredict_o, redirect_pc_o, branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/mor1kx_branch_resolve_simple.sv
// Conditional branch resolver: holds one predicted l.bf/l.bnf until execute
// supplies the real flag, then pulses a mispredict with the corrected PC.
module mor1kx_branch_resolve_simple #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int CNT_WIDTH            = 16
) (
    input  logic clk,
    input  logic rst_n,
    mor1kx_branch_resolve_simple_if.slave bus
);
    localparam int W   = OPTION_OPERAND_WIDTH;
    localparam int PAD = OPTION_OPERAND_WIDTH - 28;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic           held_bf;
    logic           held_pred;
    logic [W-1:0]   held_target;
    logic [W-1:0]   held_fallthrough;

    logic           mispredict;
    logic [W-1:0]   redirect_pc;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispredict_cnt;

    logic           is_branch;
    logic           resolve;
    logic           capture;
    logic           taken;
    logic           wrong;
    logic [W-1:0]   offset;
    logic [W-1:0]   target;
    logic [W-1:0]   fallthrough;

    // A flush overrides everything: no resolution and no new capture that cycle.
    assign is_branch   = (bus.op_bf_i | bus.op_bnf_i) & bus.padv_decode_i;
    assign resolve     = (state == PENDING) & bus.flag_valid_i & ~bus.pipeline_flush_i;
    assign capture     = is_branch & ((state == IDLE) | resolve) & ~bus.pipeline_flush_i;
    assign taken       = held_bf ? bus.flag_i : ~bus.flag_i;
    assign wrong       = resolve & (taken != held_pred);
    assign offset      = {{PAD{bus.immjbr_i[25]}}, bus.immjbr_i, 2'b00};
    assign target      = bus.pc_decode_i + offset;
    assign fallthrough = bus.pc_decode_i + W'(8);

    assign bus.busy_o           = (state == PENDING) & ~bus.flag_valid_i;
    assign bus.mispredict_o     = mispredict;
    assign bus.redirect_pc_o    = redirect_pc;
    assign bus.branch_cnt_o     = branch_cnt;
    assign bus.mispredict_cnt_o = mispredict_cnt;

    // Next state: a same-cycle capture keeps the FSM pending on the new branch.
    always_comb begin
        next_state = state;
        if (bus.pipeline_flush_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (capture) next_state = PENDING;
                PENDING: if (bus.flag_valid_i) next_state = capture ? PENDING : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Held branch: prediction, both candidate PCs and the branch sense.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_bf          <= 1'b0;
            held_pred        <= 1'b0;
            held_target      <= '0;
            held_fallthrough <= '0;
        end else if (capture) begin
            held_bf          <= bus.op_bf_i;
            held_pred        <= bus.predicted_flag_i;
            held_target      <= target;
            held_fallthrough <= fallthrough;
        end
    end

    // Mispredict pulse one cycle after the flag; redirect PC holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= wrong;
            if (wrong) redirect_pc <= taken ? held_target : held_fallthrough;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (resolve && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            if (wrong && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_mor1kx_branch_resolve_simple.sv
// Self-checking bench for the branch resolver with a queue-based reference model.
module tb_mor1kx_branch_resolve_simple;
    localparam int W = 32;
    localparam int C = 4;

    logic clk;
    logic rst_n;

    mor1kx_branch_resolve_simple_if #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(C)) bus ();

    mor1kx_branch_resolve_simple #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bf;
        logic        pred;
        logic [31:0] pc;
        logic [25:0] imm;
    } br_t;

    br_t         held_q[$];
    int          m_branches;
    int          m_mispred;
    logic        exp_mis;
    logic [31:0] exp_redirect;
    logic        exp_busy;
    logic        obs_busy;
    int          checks;
    int          errors;

    function automatic logic [C-1:0] sat(input int n);
        return (n > (1 << C) - 1) ? C'((1 << C) - 1) : C'(n);
    endfunction

    task automatic reset_model();
        held_q.delete();
        m_branches   = 0;
        m_mispred    = 0;
        exp_mis      = 1'b0;
        exp_redirect = 32'h0;
    endtask

    // One clock: drive at negedge, sample busy before the edge, update the
    // model at the edge, return at the next negedge for sampling.
    task automatic step(input logic padv, input logic bf, input logic bnf,
                        input logic pred, input logic [31:0] pc, input logic [25:0] imm,
                        input logic fv, input logic flag, input logic flush);
        br_t b;
        logic tk;
        int off;
        bus.padv_decode_i    = padv;
        bus.op_bf_i          = bf;
        bus.op_bnf_i         = bnf;
        bus.predicted_flag_i = pred;
        bus.pc_decode_i      = pc;
        bus.immjbr_i         = imm;
        bus.flag_valid_i     = fv;
        bus.flag_i           = flag;
        bus.pipeline_flush_i = flush;
        #1;
        obs_busy = bus.busy_o;
        exp_busy = (held_q.size() != 0) && !fv;
        exp_mis  = 1'b0;
        if (flush) begin
            held_q.delete();
        end else begin
            if (held_q.size() != 0 && fv) begin
                b  = held_q.pop_front();
                tk = b.bf ? flag : !flag;
                m_branches++;
                if (tk != b.pred) begin
                    m_mispred++;
                    exp_mis = 1'b1;
                    off = $signed(b.imm);
                    exp_redirect = tk ? (b.pc + 32'(off * 4)) : (b.pc + 32'd8);
                end
            end
            if ((bf || bnf) && padv && held_q.size() == 0) begin
                b.bf = bf; b.pred = pred; b.pc = pc; b.imm = imm;
                held_q.push_back(b);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cap(input logic bf, input logic pred, input logic [31:0] pc, input logic [25:0] imm);
        step(1'b1, bf, !bf, pred, pc, imm, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic flag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1, flag, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.padv_decode_i = 0; bus.op_bf_i = 0; bus.op_bnf_i = 0; bus.predicted_flag_i = 0;
        bus.pc_decode_i = 0; bus.immjbr_i = 0; bus.flag_valid_i = 0; bus.flag_i = 0;
        bus.pipeline_flush_i = 0;
        rst_n = 1'b0;
        reset_model();
        #2;
        checks++;
        if ({bus.busy_o, bus.mispredict_o, bus.redirect_pc_o, bus.branch_cnt_o, bus.mispredict_cnt_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got busy=%0b mis=%0b pc=%0h bc=%0h mc=%0h required all 0",
                     bus.busy_o, bus.mispredict_o, bus.redirect_pc_o, bus.branch_cnt_o, bus.mispredict_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // flag_valid while idle must be ignored
        res(1'b0);
        checks++;
        if (bus.mispredict_o !== 1'b0 || bus.branch_cnt_o !== 4'h0) begin
            errors++;
            $display("[TB] FAIL idle_flag_ignored got mis=%0b bc=%0h required 0 0", bus.mispredict_o, bus.branch_cnt_o);
        end
    endtask

    task automatic test_correct_prediction();
        do_reset();
        cap(1'b1, 1'b1, 32'h1000, 26'h3FFFFFC);
        idle();
        checks++;
        if (obs_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL correct_busy got %0b required 1", obs_busy);
        end
        res(1'b1);
        checks++;
        if (bus.mispredict_o !== 1'b0 || bus.branch_cnt_o !== 4'd1 || bus.mispredict_cnt_o !== 4'd0) begin
            errors++;
            $display("[TB] FAIL correct_pred got mis=%0b bc=%0d mc=%0d required 0 1 0",
                     bus.mispredict_o, bus.branch_cnt_o, bus.mispredict_cnt_o);
        end
    endtask

    task automatic test_mispredict_forward();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 26'd16, 1'b0, 1'b0, 1'b0);
        res(1'b1);
        checks++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h2008 || bus.mispredict_cnt_o !== 4'd1) begin
            errors++;
            $display("[TB] FAIL mispredict_fwd got mis=%0b pc=%0h mc=%0d required 1 2008 1",
                     bus.mispredict_o, bus.redirect_pc_o, bus.mispredict_cnt_o);
        end
        idle();
        checks++;
        if (bus.mispredict_o !== 1'b0 || bus.redirect_pc_o !== 32'h2008) begin
            errors++;
            $display("[TB] FAIL pulse_one_cycle got mis=%0b pc=%0h required 0 2008", bus.mispredict_o, bus.redirect_pc_o);
        end
    endtask

    task automatic test_mispredict_backward();
        do_reset();
        cap(1'b1, 1'b0, 32'h3000, 26'h3FFFFF8);
        res(1'b1);
        checks++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h2FE0) begin
            errors++;
            $display("[TB] FAIL mispredict_bwd got mis=%0b pc=%0h required 1 2fe0", bus.mispredict_o, bus.redirect_pc_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cap(1'b1, 1'b1, 32'h4000, 26'd4);
        // resolve A (not taken -> mispredict) while capturing B
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h5000, 26'd2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_busy got %0b required 0", obs_busy);
        end
        checks++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h4008) begin
            errors++;
            $display("[TB] FAIL b2b_first got mis=%0b pc=%0h required 1 4008", bus.mispredict_o, bus.redirect_pc_o);
        end
        idle();
        checks++;
        if (obs_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_held got busy=%0b required 1", obs_busy);
        end
        // B is l.bnf predicted 0; flag 0 -> taken -> mispredict to target 0x5008
        res(1'b0);
        checks++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h5008 || bus.branch_cnt_o !== 4'd2) begin
            errors++;
            $display("[TB] FAIL b2b_second got mis=%0b pc=%0h bc=%0d required 1 5008 2",
                     bus.mispredict_o, bus.redirect_pc_o, bus.branch_cnt_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        cap(1'b1, 1'b0, 32'h6000, 26'd8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b1);
        res(1'b1);
        checks++;
        if (bus.mispredict_o !== 1'b0 || bus.branch_cnt_o !== 4'd0 || bus.mispredict_cnt_o !== 4'd0) begin
            errors++;
            $display("[TB] FAIL flush got mis=%0b bc=%0d mc=%0d required 0 0 0",
                     bus.mispredict_o, bus.branch_cnt_o, bus.mispredict_cnt_o);
        end
        idle();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle got busy=%0b required 0", obs_busy);
        end
    endtask

    task automatic test_protocol_violation();
        do_reset();
        cap(1'b1, 1'b0, 32'h7000, 26'd4);
        cap(1'b1, 1'b0, 32'h9000, 26'd100);
        res(1'b1);
        checks++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h7010 || bus.branch_cnt_o !== 4'd1) begin
            errors++;
            $display("[TB] FAIL violation got mis=%0b pc=%0h bc=%0d required 1 7010 1",
                     bus.mispredict_o, bus.redirect_pc_o, bus.branch_cnt_o);
        end
    endtask

    task automatic test_saturation_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cap(1'b1, 1'b0, 32'h100, 26'd1);
            res(1'b1);
        end
        checks++;
        if (bus.branch_cnt_o !== 4'hF || bus.mispredict_cnt_o !== 4'hF) begin
            errors++;
            $display("[TB] FAIL saturation got bc=%0h mc=%0h required f f", bus.branch_cnt_o, bus.mispredict_cnt_o);
        end
        cap(1'b1, 1'b0, 32'hFFFFFFF8, 26'd4);
        res(1'b1);
        checks++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h00000008) begin
            errors++;
            $display("[TB] FAIL wrap got mis=%0b pc=%0h required 1 8", bus.mispredict_o, bus.redirect_pc_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cap(1'b1, 1'b0, 32'hA000, 26'd4);
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.mispredict_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got busy=%0b mis=%0b required 0 0", bus.busy_o, bus.mispredict_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        res(1'b1);
        checks++;
        if (bus.mispredict_o !== 1'b0 || bus.branch_cnt_o !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_discard got mis=%0b bc=%0d required 0 0", bus.mispredict_o, bus.branch_cnt_o);
        end
    endtask

    task automatic test_random();
        logic bf;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bf = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6) && bf,
                 ($urandom_range(0, 9) < 6) && !bf, 1'($urandom_range(0, 1)),
                 $urandom, 26'($urandom), ($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
            checks++;
            if (obs_busy !== exp_busy) begin
                errors++;
                $display("[TB] FAIL rand_busy cycle %0d got %0b required %0b", i, obs_busy, exp_busy);
            end
            checks++;
            if (bus.mispredict_o !== exp_mis || bus.redirect_pc_o !== exp_redirect) begin
                errors++;
                $display("[TB] FAIL rand_redirect cycle %0d got mis=%0b pc=%0h required %0b %0h",
                         i, bus.mispredict_o, bus.redirect_pc_o, exp_mis, exp_redirect);
            end
            checks++;
            if (bus.branch_cnt_o !== sat(m_branches) || bus.mispredict_cnt_o !== sat(m_mispred)) begin
                errors++;
                $display("[TB] FAIL rand_counts cycle %0d got bc=%0d mc=%0d required %0d %0d",
                         i, bus.branch_cnt_o, bus.mispredict_cnt_o, sat(m_branches), sat(m_mispred));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_correct_prediction();
        test_mispredict_forward();
        test_mispredict_backward();
        test_back_to_back();
        test_flush();
        test_protocol_violation();
        test_saturation_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mor1kx_branch_resolve_simple.md
Name: mor1kx_branch_resolve_simple

Overview:
- Downstream partner of the static branch predictor. Captures each predicted conditional branch (l.bf/l.bnf) leaving decode, holds it until execute produces the real SR[F] flag, then compares.
- On mismatch: raises a one-cycle mispredict pulse with the corrected fetch PC; fetch and control use it to flush and redirect.
- Keeps saturating branch and mispredict counters for SPR performance readout.

Parameters:
- OPTION_OPERAND_WIDTH, 32, width of PCs and redirect address.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- padv_decode_i  in  1  decode stage advances this cycle.
- op_bf_i  in  1  decode instruction is l.bf.
- op_bnf_i  in  1  decode instruction is l.bnf.
- predicted_flag_i  in  1  predictor result for the decode instruction.
- pc_decode_i  in  OPTION_OPERAND_WIDTH  PC of the decode branch.
- immjbr_i  in  26  branch word offset.
- flag_valid_i  in  1  execute has a final flag for the held branch this cycle.
- flag_i  in  1  actual SR[F], qualified by flag_valid_i.
- pipeline_flush_i  in  1  exception or rfe flush; discards the held branch.
- busy_o  out  1  a branch is held and unresolved; decode must not advance a new branch.
- mispredict_o  out  1  one-cycle pulse: prediction was wrong.
- redirect_pc_o  out  OPTION_OPERAND_WIDTH  correct next-fetch PC, valid while mispredict_o=1.
- branch_cnt_o  out  CNT_WIDTH  resolved conditional branches.
- mispredict_cnt_o  out  CNT_WIDTH  mispredicted branches.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, held registers 0.
- Capture: (op_bf_i|op_bnf_i) & padv_decode_i & (state==IDLE | resolving this cycle). On capture, register:
  - predicted_flag_i;
  - target = pc_decode_i + (sign-extended immjbr_i << 2), truncated to OPTION_OPERAND_WIDTH (wrap-around allowed);
  - fallthrough = pc_decode_i + 8 (the delay slot is always executed);
  - branch type.
- FSM states:
  - IDLE -> PENDING on capture.
  - PENDING, flag_valid_i=1 -> resolve. Go to PENDING if a new capture happens the same cycle, else IDLE.
  - PENDING, flag_valid_i=0 -> stay PENDING.
  - Any state, pipeline_flush_i=1 -> IDLE. A capture in the same cycle is dropped, and no resolution, pulse or count update happens.
- Resolve: taken = bf ? flag_i : ~flag_i. Mispredict when taken != held predicted_flag.
  - On the next clock edge: mispredict_o=1 for exactly one cycle, and redirect_pc_o = taken ? target : fallthrough. Latency is one cycle from flag_valid_i to mispredict_o.
  - mispredict_o=0 otherwise. redirect_pc_o holds its last value.
- Counters: branch_cnt increments by 1 per resolve; mispredict_cnt increments by 1 per mispredict. Both saturate at all-ones and never wrap.
- busy_o = (state==PENDING) & ~flag_valid_i. It is combinational, so back-to-back branches resolve without a bubble.
- Protocol violation: a capture attempt while busy_o=1 is ignored, and the held branch is preserved.
- flag_valid_i while IDLE is ignored.
- Asynchronous reset mid-PENDING: the held branch is discarded immediately and no pulse is produced.

Test Plan:
- Correct prediction: l.bf, pc=0x1000, imm=-4 (0x3FFFFFC), predicted=1; flag_valid_i=1, flag_i=1 two cycles later -> mispredict_o stays 0, branch_cnt=1, mispredict_cnt=0.
- Mispredict forward: l.bnf, pc=0x2000, imm=+16, predicted=1; flag_i=1 -> mispredict_o pulses 1 cycle, redirect_pc_o=0x2008, mispredict_cnt=1.
- Mispredict backward taken: l.bf, pc=0x3000, imm=-8, predicted=0; flag_i=1 -> redirect_pc_o=0x2FE0.
- Back-to-back: resolve branch A and capture branch B in the same cycle -> busy_o=0 that cycle, state stays PENDING holding B, and B later resolves independently.
- Flush: pipeline_flush_i asserted while PENDING, with a later flag_valid_i -> no pulse, counters unchanged, state IDLE.
- Saturation and wrap: CNT_WIDTH=4, 20 mispredicts -> both counters read 0xF. pc=0xFFFFFFF8, imm=+4 -> target wraps to 0x00000008.
